conv_stream_engine: RTL and testbench

CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_line_buffer.sv | 36 +++
 rtl/conv_stream_engine.sv | 202 ++++++++++++++++++++
 tb/tb_conv_stream_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the streaming KxK convolution engine: FSM encoding,
// width helpers and the accumulator width derivation.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Port/counter width: never narrower than one bit.
   function automatic int idx_w(input int v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

   function automatic int acc_w(input int data_w, input int k);
      return 2*data_w + 1 + clog2(k*k);
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: a circular buffer that advances only on accepted pixels.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter  int IMG_W  = 16,
   parameter  int DATA_W = 8,
   localparam int PW     = idx_w(IMG_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [IMG_W];
   logic [PW-1:0]     ptr_q, ptr_d;

   // The slot about to be overwritten holds the pixel from exactly one row ago.
   assign dout = mem[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (en) ptr_d = (ptr_q == PW'(IMG_W-1)) ? '0 : ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

   always_ff @(posedge clk) begin
      if (en) mem[ptr_q] <= din;
   end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution over a raster pixel stream, CONV_NUM filters in
// parallel, one registered result per fully populated window.
module conv_stream_engine
   import conv_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int CONV_NUM = 2,
   parameter  int K        = 3,
   parameter  int IMG_W    = 16,
   parameter  int IMG_H    = 16,
   localparam int ACC_W    = acc_w(DATA_W, K),
   localparam int FW       = idx_w(CONV_NUM),
   localparam int IW       = idx_w(K*K),
   localparam int RW       = idx_w(IMG_H),
   localparam int CW       = idx_w(IMG_W)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   input  logic                      w_we,
   input  logic [FW-1:0]             w_filt,
   input  logic [IW-1:0]             w_idx,
   input  logic [DATA_W-1:0]         w_data,
   input  logic                      pix_valid,
   output logic                      pix_ready,
   input  logic [DATA_W-1:0]         pix_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CONV_NUM*ACC_W-1:0] out_data,
   output logic [RW-1:0]             out_row,
   output logic [CW-1:0]             out_col
);

   state_e                    state_q, state_d;
   logic                      busy_q, busy_d, done_q, done_d;
   logic [RW-1:0]             row_q, row_d;
   logic [CW-1:0]             col_q, col_d;
   logic                      last_pix_q, last_pix_d;
   logic signed [DATA_W-1:0]  weight_q [CONV_NUM][K*K];
   logic signed [DATA_W-1:0]  weight_d [CONV_NUM][K*K];
   logic [DATA_W-1:0]         win_q [K][K];
   logic [DATA_W-1:0]         win_d [K][K];
   logic [DATA_W-1:0]         tap [K];
   logic [DATA_W-1:0]         lb_in [K-1];
   logic [DATA_W-1:0]         lb_out [K-1];
   logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [CONV_NUM*ACC_W-1:0] out_data_q, out_data_d;
   logic [RW-1:0]             out_row_q, out_row_d;
   logic [CW-1:0]             out_col_q, out_col_d;
   logic signed [ACC_W-1:0]   sum [CONV_NUM];
   logic signed [ACC_W-1:0]   px_e, w_e;
   logic                      pix_acc, res_take;

   // last_pix_q stops intake once the frame's final pixel is in, while its result drains.
   assign pix_ready = (state_q == ST_STREAM) && !last_pix_q && (!out_valid_q || out_ready);
   assign pix_acc   = pix_valid && pix_ready;
   assign res_take  = out_valid_q && out_ready;

   // tap[i] feeds window row i; row K-1 is the incoming pixel, row 0 the oldest line.
   genvar gi;
   generate
      for (gi = 0; gi < K-1; gi++) begin : g_lb
         if (gi == 0) begin : g_first
            assign lb_in[gi] = pix_data;
         end else begin : g_next
            assign lb_in[gi] = lb_out[gi-1];
         end
         conv_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (pix_acc),
            .din  (lb_in[gi]),
            .dout (lb_out[gi])
         );
         assign tap[K-2-gi] = lb_out[gi];
      end
   endgenerate
   assign tap[K-1] = pix_data;

   always_comb begin
      win_d = win_q;
      if (pix_acc) begin
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) win_d[i][j] = win_q[i][j+1];
            win_d[i][K-1] = tap[i];
         end
      end
   end

   // Multiply-add on the post-shift window so the result registers with the pixel.
   always_comb begin
      px_e = '0;
      w_e  = '0;
      for (int f = 0; f < CONV_NUM; f++) begin
         sum[f] = '0;
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               px_e   = ACC_W'({1'b0, win_d[i][j]});
               w_e    = ACC_W'(weight_q[f][i*K+j]);
               sum[f] = sum[f] + px_e * w_e;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      last_pix_d  = last_pix_q;
      weight_d    = weight_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      case (state_q)
         ST_IDLE: begin
            if (w_we && (int'(w_filt) < CONV_NUM) && (int'(w_idx) < K*K))
               weight_d[w_filt][w_idx] = w_data;
            if (start) begin
               state_d     = ST_STREAM;
               row_d       = '0;
               col_d       = '0;
               last_pix_d  = 1'b0;
               out_valid_d = 1'b0;
            end
         end
         ST_STREAM: begin
            if (res_take) begin
               out_valid_d = 1'b0;
               if (out_last_q) state_d = ST_DONE;
            end
            if (pix_acc) begin
               if (col_q == CW'(IMG_W-1)) begin
                  col_d = '0;
                  if (row_q == RW'(IMG_H-1)) last_pix_d = 1'b1;
                  else                       row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               // Only windows lying wholly inside one set of K rows/cols emit a result.
               if ((row_q >= RW'(K-1)) && (col_q >= CW'(K-1))) begin
                  out_valid_d = 1'b1;
                  out_row_d   = row_q - RW'(K-1);
                  out_col_d   = col_q - CW'(K-1);
                  out_last_d  = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
                  for (int f = 0; f < CONV_NUM; f++) out_data_d[f*ACC_W +: ACC_W] = sum[f];
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_STREAM);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         last_pix_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         for (int f = 0; f < CONV_NUM; f++)
            for (int n = 0; n < K*K; n++) weight_q[f][n] <= '0;
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) win_q[i][j] <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         row_q       <= row_d;
         col_q       <= col_d;
         last_pix_q  <= last_pix_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         weight_q    <= weight_d;
         win_q       <= win_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine on a 4x4 image, 3x3 kernel, two filters.
module tb_conv_stream_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        busy, done;
   logic        w_we = 1'b0;
   logic [0:0]  w_filt = '0;
   logic [3:0]  w_idx = '0;
   logic [7:0]  w_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [7:0]  pix_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [41:0] out_data;
   logic [1:0]  out_row, out_col;

   conv_stream_engine #(.DATA_W(8), .CONV_NUM(2), .K(3), .IMG_W(4), .IMG_H(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .w_we      (w_we),
      .w_filt    (w_filt),
      .w_idx     (w_idx),
      .w_data    (w_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_data  (pix_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col)
   );

   always #5 clk = ~clk;

   typedef struct {
      int row;
      int col;
      int f0;
      int f1;
   } vec_t;

   vec_t vec [12];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // mode 0: filter 0 all ones, filter 1 centre tap only; mode 1: all weights -128
   task automatic load_weights(input int mode);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            w_we   = 1'b1;
            w_filt = 1'(f);
            w_idx  = 4'(i);
            if (mode == 0) w_data = (f == 0 || i == 4) ? 8'd1 : 8'd0;
            else           w_data = 8'h80;
         end
      end
      @(negedge clk);
      w_we = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int mode, input int base,
                            input int bp, input int ign);
      int          pix_i, res_i, hold, done_cnt;
      logic [41:0] hold_data;
      logic [1:0]  hold_row, hold_col;
      pix_i = 0; res_i = 0; hold = 0; done_cnt = 0;
      hold_data = '0; hold_row = '0; hold_col = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1 chk({tag, "_busy_after_start"}, int'(busy), 1);
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         start     = (ign != 0 && cyc == 3);
         w_we      = (ign != 0 && cyc == 3);
         w_filt    = '0;
         w_idx     = '0;
         w_data    = 8'h63;
         pix_valid = 1'b1;
         if (pix_i >= 16)    pix_data = 8'hEE;
         else if (mode == 1) pix_data = 8'hFF;
         else                pix_data = 8'(pix_i);
         out_ready = !(bp != 0 && res_i == 0 && hold < 5);
         #1;
         if (done) begin
            done_cnt++;
            chk({tag, "_busy_at_done"}, int'(busy), 0);
         end
         if (ign != 0 && cyc == 4) chk({tag, "_busy_after_ignored_start"}, int'(busy), 1);
         if (out_valid && !out_ready) begin
            chk({tag, "_pix_ready_in_hold"}, int'(pix_ready), 0);
            if (hold == 0) begin
               hold_data = out_data; hold_row = out_row; hold_col = out_col;
            end else begin
               chk({tag, "_hold_data_stable"}, int'(out_data == hold_data), 1);
               chk({tag, "_hold_pos_stable"}, int'({out_row, out_col} == {hold_row, hold_col}), 1);
            end
            hold++;
         end
         if (pix_valid && pix_ready) pix_i++;
         if (out_valid && out_ready) begin
            $display("[%s] result %0d row=%0d col=%0d f0=%0d f1=%0d", tag, res_i,
                     out_row, out_col, $signed(out_data[20:0]), $signed(out_data[41:21]));
            if (res_i < 4) begin
               chk({tag, "_row"}, int'(out_row), vec[base+res_i].row);
               chk({tag, "_col"}, int'(out_col), vec[base+res_i].col);
               chk({tag, "_f0"}, $signed(out_data[20:0]), vec[base+res_i].f0);
               chk({tag, "_f1"}, $signed(out_data[41:21]), vec[base+res_i].f1);
            end
            res_i++;
         end
      end
      pix_valid = 1'b0; start = 1'b0; w_we = 1'b0; out_ready = 1'b0;
      chk({tag, "_result_count"}, res_i, 4);
      chk({tag, "_pixels_accepted"}, pix_i, 16);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      if (bp != 0) chk({tag, "_hold_cycles"}, hold, 5);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_pix_ready"}, int'(pix_ready), 0);
      chk({tag, "_out_data"}, int'(out_data != '0), 0);
      chk({tag, "_out_row"}, int'(out_row), 0);
      chk({tag, "_out_col"}, int'(out_col), 0);
   endtask

   initial begin
      int pix_i;
      vec[0]  = '{0, 0, 45, 5};
      vec[1]  = '{0, 1, 54, 6};
      vec[2]  = '{1, 0, 81, 9};
      vec[3]  = '{1, 1, 90, 10};
      vec[4]  = '{0, 0, -293760, -293760};
      vec[5]  = '{0, 1, -293760, -293760};
      vec[6]  = '{1, 0, -293760, -293760};
      vec[7]  = '{1, 1, -293760, -293760};
      vec[8]  = '{0, 0, 0, 0};
      vec[9]  = '{0, 1, 0, 0};
      vec[10] = '{1, 0, 0, 0};
      vec[11] = '{1, 1, 0, 0};

      #2 check_outputs_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      load_weights(0);
      run_frame("window", 0, 0, 0, 0);
      load_weights(1);
      run_frame("extreme", 1, 4, 0, 0);
      load_weights(0);
      run_frame("backpressure", 0, 0, 1, 0);
      run_frame("ignored", 0, 0, 0, 1);

      // Reset in the middle of a frame, right after pixel 9 is taken.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pix_i = 0;
      for (int cyc = 0; cyc < 40 && pix_i < 10; cyc++) begin
         @(negedge clk);
         pix_valid = 1'b1;
         pix_data  = 8'(pix_i);
         out_ready = 1'b1;
         #1;
         if (pix_valid && pix_ready) pix_i++;
      end
      chk("midreset_pixels_before_reset", pix_i, 10);
      @(posedge clk);
      #2 rst = 1'b0;
      pix_valid = 1'b0;
      out_ready = 1'b0;
      #1 check_outputs_zero("midreset");
      @(negedge clk);
      rst = 1'b1;
      run_frame("cleared_weights", 0, 8, 0, 0);
      load_weights(0);
      run_frame("rerun", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
